// File: rtl/drop_controller.sv
// Baggage-drop sequencer: sensor average -> iterative divide -> bit-serial sqrt -> limit compare -> timed drop pulse.
// Optional STICKY_FAULT_EN: fault latches until rst and blocks all later drops.
module drop_controller #(
  parameter int DROP_HOLD = 4,
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  sensor1,
  input  logic [7:0]  sensor2,
  input  logic [7:0]  sensor3,
  input  logic [7:0]  sensor4,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  height,
  output logic [15:0] t_half,
  output logic        fault,
  output logic        drop_activated
);
  localparam int RW  = 8 + FRAC_BITS;
  localparam int HCW = $clog2(DROP_HOLD + 1);

  typedef enum logic [2:0] {IDLE, DIVIDE, SQRT, DECIDE, DROP} state_t;
  state_t state;

  logic [4:0]        it;
  logic [HCW-1:0]    hold;
  logic              fault_int;
  logic [9:0]        div_q;
  logic [3:0]        div_r;
  logic [2:0]        div_d;
  logic [2*RW-1:0]   sq_rad;
  logic [RW+1:0]     sq_rem;
  logic [RW-1:0]     sq_root;

  logic [3:0][7:0]   sens;
  logic [9:0]        s_sum;
  logic [2:0]        s_cnt;
  always_comb begin
    sens  = {sensor4, sensor3, sensor2, sensor1};
    s_sum = '0;
    s_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (sens[i] != 8'd0) begin
        s_sum = s_sum + {2'b00, sens[i]};
        s_cnt = s_cnt + 3'd1;
      end
    end
  end

  // Restoring divide step; remainder stays below the divisor (<=4), so 4 bits suffice.
  logic [4:0] div_sh;
  logic       div_ge;
  logic [3:0] div_r_nxt;
  logic [9:0] div_q_nxt;
  always_comb begin
    div_sh    = {div_r, div_q[9]};
    div_ge    = div_sh >= {2'b00, div_d};
    div_r_nxt = div_ge ? 4'(div_sh - {2'b00, div_d}) : div_sh[3:0];
    div_q_nxt = {div_q[8:0], div_ge};
  end

  // Restoring sqrt step: bring down two radicand bits, try subtracting (root<<2)|1.
  logic [RW+3:0] sq_sh;
  logic [RW+3:0] sq_trial;
  logic          sq_ge;
  logic [RW+1:0] sq_rem_nxt;
  always_comb begin
    sq_sh      = {sq_rem, sq_rad[2*RW-1 -: 2]};
    sq_trial   = {2'b00, sq_root, 2'b01};
    sq_ge      = sq_sh >= sq_trial;
    sq_rem_nxt = sq_ge ? (RW+2)'(sq_sh - sq_trial) : sq_sh[RW+1:0];
  end

  logic [7:0]  h_nxt;
  logic [15:0] th_nxt;
  logic        fault_nxt;
  logic        grant;
  always_comb begin
    h_nxt  = fault_int ? 8'd0  : div_q[7:0];
    th_nxt = fault_int ? 16'd0 : 16'(sq_root >> 1);
`ifdef STICKY_FAULT_EN
    fault_nxt = fault | fault_int;
`else
    fault_nxt = fault_int;
`endif
    grant = drop_en && !fault_nxt && (th_nxt <= t_lim);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      height         <= '0;
      t_half         <= '0;
      fault          <= 1'b0;
      drop_activated <= 1'b0;
      it             <= '0;
      hold           <= '0;
      fault_int      <= 1'b0;
      div_q          <= '0;
      div_r          <= '0;
      div_d          <= '0;
      sq_rad         <= '0;
      sq_rem         <= '0;
      sq_root        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          div_q     <= s_sum;
          div_r     <= '0;
          div_d     <= s_cnt;
          fault_int <= (s_cnt == 3'd0);
          it        <= '0;
          busy      <= 1'b1;
          state     <= (s_cnt == 3'd0) ? DECIDE : DIVIDE;
        end
        DIVIDE: begin
          div_q <= div_q_nxt;
          div_r <= div_r_nxt;
          if (it == 5'd9) begin
            it      <= '0;
            sq_rad  <= (2*RW)'({div_q_nxt[7:0], {(2*FRAC_BITS){1'b0}}});
            sq_rem  <= '0;
            sq_root <= '0;
            state   <= SQRT;
          end else begin
            it <= it + 5'd1;
          end
        end
        SQRT: begin
          sq_rad  <= sq_rad << 2;
          sq_rem  <= sq_rem_nxt;
          sq_root <= {sq_root[RW-2:0], sq_ge};
          if (it == 5'(RW-1)) state <= DECIDE;
          else                it    <= it + 5'd1;
        end
        DECIDE: begin
          height <= h_nxt;
          t_half <= th_nxt;
          fault  <= fault_nxt;
          done   <= 1'b1;
          if (grant) begin
            drop_activated <= 1'b1;
            hold           <= HCW'(DROP_HOLD - 1);
            state          <= DROP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DROP: begin
          if (!drop_en || hold == '0) begin
            drop_activated <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else begin
            hold <= hold - HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller: stimulus pushes expected results, a negedge monitor checks each done.
module tb_drop_controller;
  logic        clk = 1'b0;
  logic        rst, start, drop_en;
  logic [7:0]  sensor1, sensor2, sensor3, sensor4;
  logic [15:0] t_lim;
  logic        busy, done, fault, drop_activated;
  logic [7:0]  height;
  logic [15:0] t_half;

`ifdef STICKY_FAULT_EN
  localparam int STK = 1;
`else
  localparam int STK = 0;
`endif

  drop_controller #(.DROP_HOLD(4), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .t_lim(t_lim), .drop_en(drop_en),
    .busy(busy), .done(done), .height(height), .t_half(t_half),
    .fault(fault), .drop_activated(drop_activated)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, t, f, len, lat, issue;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: on each done, pop the oldest expectation and measure the drop pulse that follows.
  always begin
    exp_t e;
    int len;
    @(negedge clk);
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc - e.issue, e.lat);
        check("height",  int'(height), e.h);
        check("t_half",  int'(t_half), e.t);
        check("fault",   int'(fault),  e.f);
        len = 0;
        while (drop_activated && len < 20) begin
          len++;
          @(negedge clk);
        end
        check("drop_len", len, e.len);
        check("busy_after", int'(busy), 0);
      end
      done_cnt++;
    end
  end

  task automatic run(input logic [7:0] a, b, c, d, input int tl, en,
                     input int h, t, f, len, lat, input bit extra, input bit abort);
    exp_t e;
    int base, n;
    @(negedge clk);
    sensor1 = a; sensor2 = b; sensor3 = c; sensor4 = d;
    t_lim = 16'(tl); drop_en = en[0];
    e.h = h; e.t = t; e.f = f; e.len = len; e.lat = lat; e.issue = cyc + 1;
    exp_q.push_back(e);
    base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(done_cnt != base && !busy) && n < 80) begin
      if (abort && done) begin
        @(negedge clk);
        drop_en = 1'b0;
      end
      start = extra && (n == 3 || n == 18);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 80) begin
      check("timeout", 0, 1);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; drop_en = 1'b0; t_lim = '0;
    sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_height", int'(height), 0);
    check("rst_t_half", int'(t_half), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_drop",  int'(drop_activated), 0);
    rst = 1'b0;

    //  sensors            t_lim en   h    t    f    len lat extra abort
    run(16, 16, 16, 16,    512,  1,  16,  512, 0,   4,  27, 0, 0);
    run(16, 16, 16, 16,    511,  1,  16,  512, 0,   0,  27, 0, 0);
    run(0, 9, 9, 12,       1000, 1,  10,  404, 0,   4,  27, 0, 0);
    run(0, 9, 9, 12,       1000, 0,  10,  404, 0,   0,  27, 0, 0);
    run(0, 0, 0, 200,      1810, 1,  200, 1810, 0,  4,  27, 0, 0);
    run(16, 16, 16, 16,    512,  1,  16,  512, 0,   4,  27, 1, 0);
    run(0, 9, 9, 12,       1000, 1,  10,  404, 0,   2,  27, 0, 1);
    run(0, 0, 0, 0,        1000, 1,  0,   0,   1,   0,  1,  0, 0);
    run(255, 255, 255, 255, 3000, 1, 255, 2043, STK, STK ? 0 : 4, 27, 0, 0);

    // Reset in the middle of the square-root phase.
    @(negedge clk);
    sensor1 = 16; sensor2 = 16; sensor3 = 16; sensor4 = 16; drop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_sqrt_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",   int'(busy), 0);
    check("mrst_height", int'(height), 0);
    check("mrst_t_half", int'(t_half), 0);
    check("mrst_fault",  int'(fault), 0);
    check("mrst_drop",   int'(drop_activated), 0);
    repeat (40) @(negedge clk);
    check("mrst_idle", int'(busy), 0);

    run(0, 9, 9, 12,       1000, 1,  10,  404, 0,   4,  27, 0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
